fetch_ctrl: RTL and testbench

Fetch-stage sequencer placed between the pipeline's next-PC selection and a variable-latency instruction memory port. It owns the fetch PC and issues one instruction request at a time. It discards responses made stale by an Execute-stage redirect (branch, JAL or JALR) and holds the fetched instruction steady while Decode is stalled. It replaces the direct PC-to-memory connection of a single-cycle instruction ROM so that a cached or wait-stated memory can sit behind the Fetch stage.

---
 rtl/fetch_ctrl_if.sv | 22 ++
 rtl/fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction memory request/response port between the fetch sequencer
// (master) and the instruction memory or cache (slave).
interface fetch_ctrl_if;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemValid;
  logic [31:0] MemRData;

  modport master (
    output MemReq,
    output MemAddr,
    input  MemValid,
    input  MemRData
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    output MemValid,
    output MemRData
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, keeps at most one instruction
// memory request in flight, discards responses made stale by an Execute
// redirect and holds the fetched instruction while Decode is stalled.
//
// state | meaning
// ------+-----------------------------------------------------------------
// BOOT  | first cycle after reset, no request yet
// ISSUE | request pulse for fpc (no instruction held)
// WAIT  | one request outstanding; kill marks it stale
// HOLD  | instruction held on InstrF/PCF; re-issues when Decode accepts it
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   PCSrcE,
  input  logic [31:0]  PCTargetE,
  input  logic [31:0]  ALUResultE,
  input  logic         StallF,
  fetch_ctrl_if.master mem,
  output logic [31:0]  InstrF,
  output logic [31:0]  PCF,
  output logic [31:0]  PCPlus4F,
  output logic         InstrValidF
);

  typedef enum logic [1:0] {BOOT, ISSUE, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        mem_req;
  logic        redirect;
  logic [31:0] target;

  // Redirect decode; 2'b11 is treated as sequential. Targets are word aligned.
  always_comb begin
    redirect = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    target   = ((PCSrcE == 2'b10) ? ALUResultE : PCTargetE) & ~32'h0000_0003;
  end

  // Next-state, fetch PC and held-instruction update; redirect beats stall.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    pcf_d   = pcf_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    mem_req = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = ISSUE;
        if (redirect) fpc_d = target;
      end
      ISSUE: begin
        mem_req = 1'b1;
        state_d = WAIT;
        if (redirect) begin
          fpc_d  = target;
          kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem.MemValid) begin
          if (!kill_q && !redirect) begin
            instr_d = mem.MemRData;
            pcf_d   = fpc_q;
            pcp4_d  = fpc_q + 32'd4;
            valid_d = 1'b1;
            fpc_d   = fpc_q + 32'd4;
            state_d = HOLD;
          end else begin
            // Stale response: drop it and re-issue from the current fpc.
            kill_d  = 1'b0;
            if (redirect) fpc_d = target;
            state_d = ISSUE;
          end
        end else if (redirect) begin
          fpc_d  = target;
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          fpc_d   = target;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = ISSUE;
        end else if (!StallF) begin
          // Decode takes the instruction; fetch the next one in the same cycle.
          mem_req = 1'b1;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = WAIT;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      fpc_q   <= RESET_PC;
      kill_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pcf_q   <= RESET_PC;
      pcp4_q  <= RESET_PC + 32'd4;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      pcf_q   <= pcf_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign mem.MemReq  = mem_req;
  assign mem.MemAddr = fpc_q;
  assign InstrF      = instr_q;
  assign PCF         = pcf_q;
  assign PCPlus4F    = pcp4_q;
  assign InstrValidF = valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a variable-latency memory model answers each
// request; expected request addresses and fetched instructions are queued as
// the stimulus is written and checked when the DUT produces them.
module tb_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;
  logic        StallF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        InstrValidF;

  fetch_ctrl_if mif ();

  fetch_ctrl #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .ALUResultE (ALUResultE),
    .StallF     (StallF),
    .mem        (mif.master),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .InstrValidF(InstrValidF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        g_rst = 1'b1;
  logic        g_stall = 1'b0;
  logic [1:0]  g_src = 2'b00;
  logic [31:0] g_tgt = 32'h0;
  logic [31:0] g_alu = 32'h0;
  logic        obs_en = 1'b0;
  logic        prev_valid = 1'b0;
  logic        new_seen = 1'b0;
  logic        req_seen = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          resp_cyc = 0;
  int          last_resp_cyc = 0;
  logic [31:0] req_q[$];
  logic [31:0] instr_q[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, let the memory model respond, then observe.
  task automatic step();
    logic [31:0] pc;
    @(posedge clk);
    #1;
    cyc++;
    rst        = g_rst;
    StallF     = g_stall;
    PCSrcE     = g_src;
    PCTargetE  = g_tgt;
    ALUResultE = g_alu;
    if (pend && cyc == resp_cyc) begin
      mif.MemValid = 1'b1;
      mif.MemRData = data_of(pend_addr);
      pend = 1'b0;
      last_resp_cyc = cyc;
    end else begin
      mif.MemValid = 1'b0;
      mif.MemRData = 32'h0;
    end
    #2;
    new_seen = 1'b0;
    req_seen = 1'b0;
    if (obs_en) begin
      if (mif.MemReq === 1'b1) begin
        req_seen = 1'b1;
        chk("req_while_outstanding", {31'b0, pend}, 32'd0);
        chk("req_expected", req_q.size(), 32'd1 <= req_q.size() ? req_q.size() : 32'd1);
        if (req_q.size() > 0) chk("req_addr", mif.MemAddr, req_q.pop_front());
        pend = 1'b1;
        pend_addr = mif.MemAddr;
        resp_cyc = cyc + lat;
      end
      if (InstrValidF === 1'b1 && !prev_valid) begin
        new_seen = 1'b1;
        chk("instr_expected", {31'b0, instr_q.size() > 0}, 32'd1);
        if (instr_q.size() > 0) begin
          pc = instr_q.pop_front();
          chk("pcf", PCF, pc);
          chk("instrf", InstrF, data_of(pc));
          chk("pcplus4f", PCPlus4F, pc + 32'd4);
        end
      end
      if (InstrValidF !== 1'b1) chk("nop_when_invalid", InstrF, NOP);
      prev_valid = (InstrValidF === 1'b1);
    end
  endtask

  task automatic wait_new(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (new_seen) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, {31'b0, got}, 32'd1);
  endtask

  task automatic apply_reset();
    g_rst = 1'b1;
    g_src = 2'b00;
    step();
    obs_en = 1'b1;
    step();
    chk("rst_memreq", {31'b0, mif.MemReq}, 32'd0);
    chk("rst_memaddr", mif.MemAddr, RPC);
    chk("rst_valid", {31'b0, InstrValidF}, 32'd0);
    chk("rst_instr", InstrF, NOP);
    chk("rst_pcf", PCF, RPC);
    chk("rst_pcp4", PCPlus4F, RPC + 32'd4);
    g_rst = 1'b0;
  endtask

  initial begin
    logic got;
    logic exp_req[6];
    rst = 1'b1; StallF = 1'b0; PCSrcE = 2'b00; PCTargetE = 32'h0; ALUResultE = 32'h0;
    mif.MemValid = 1'b0; mif.MemRData = 32'h0;
    exp_req = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Boot, L=1, no stall: requests on cycles 2, 4, 6.
    lat = 1;
    apply_reset();
    req_q.push_back(32'h100); req_q.push_back(32'h104); req_q.push_back(32'h108);
    instr_q.push_back(32'h100); instr_q.push_back(32'h104); instr_q.push_back(32'h108);
    g_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("boot_memreq_c%0d", i + 1), {31'b0, mif.MemReq}, {31'b0, exp_req[i]});
      if (i == 3) begin
        chk("boot_valid_c4", {31'b0, InstrValidF}, 32'd1);
        chk("boot_pcf_c4", PCF, 32'h100);
        chk("boot_pcp4_c4", PCPlus4F, 32'h104);
      end
    end
    g_stall = 1'b1;
    wait_new("boot_i108");

    // Stall hold, L=3.
    lat = 3;
    apply_reset();
    g_stall = 1'b1;
    req_q.push_back(32'h100); instr_q.push_back(32'h100);
    wait_new("stall_i100");
    req_q.push_back(32'h104); instr_q.push_back(32'h104);
    g_stall = 1'b0; step();
    g_stall = 1'b1;
    wait_new("stall_i104");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_instr", InstrF, data_of(32'h104));
      chk("stall_pcf", PCF, 32'h104);
      chk("stall_valid", {31'b0, InstrValidF}, 32'd1);
      chk("stall_memreq", {31'b0, mif.MemReq}, 32'd0);
    end
    req_q.push_back(32'h108);
    g_stall = 1'b0; step();
    chk("stall_release_req", {31'b0, mif.MemReq}, 32'd1);
    chk("stall_release_addr", mif.MemAddr, 32'h108);

    // Redirect during WAIT, L=4.
    instr_q.push_back(32'h108);
    g_stall = 1'b1;
    wait_new("t3_i108");
    lat = 4;
    req_q.push_back(32'h10C);
    g_stall = 1'b0; step();
    g_stall = 1'b1;
    req_q.push_back(32'h200); instr_q.push_back(32'h200);
    g_src = 2'b01; g_tgt = 32'h200; step();
    g_src = 2'b00;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (req_seen) begin
        got = 1'b1;
        break;
      end
      chk("t3_valid_low", {31'b0, InstrValidF}, 32'd0);
    end
    chk("t3_req_seen", {31'b0, got}, 32'd1);
    chk("t3_req_timing", cyc, last_resp_cyc + 1);
    wait_new("t3_i200");

    // Redirect (JALR) coincident with the response.
    lat = 2;
    req_q.push_back(32'h204);
    g_stall = 1'b0; step();
    g_stall = 1'b1; step();
    req_q.push_back(32'h300); instr_q.push_back(32'h300);
    g_src = 2'b10; g_alu = 32'h301; step();
    g_src = 2'b00; step();
    chk("t4_req", {31'b0, mif.MemReq}, 32'd1);
    chk("t4_addr", mif.MemAddr, 32'h300);
    chk("t4_valid_low", {31'b0, InstrValidF}, 32'd0);
    wait_new("t4_i300");

    // Redirect overrides stall in HOLD.
    req_q.push_back(32'h400); instr_q.push_back(32'h400);
    g_stall = 1'b1; g_src = 2'b01; g_tgt = 32'h400; step();
    chk("t5_no_req", {31'b0, mif.MemReq}, 32'd0);
    g_src = 2'b00; step();
    chk("t5_valid_low", {31'b0, InstrValidF}, 32'd0);
    chk("t5_nop", InstrF, NOP);
    chk("t5_req", {31'b0, mif.MemReq}, 32'd1);
    chk("t5_addr", mif.MemAddr, 32'h400);
    wait_new("t5_i400");

    // Wrap-around, then reset while a request is outstanding.
    lat = 1;
    req_q.push_back(32'hFFFF_FFFC); instr_q.push_back(32'hFFFF_FFFC);
    g_src = 2'b01; g_tgt = 32'hFFFF_FFFE; step();
    g_src = 2'b00;
    wait_new("t6_iwrap");
    chk("t6_pcp4_wrap", PCPlus4F, 32'h0);
    req_q.push_back(32'h0); instr_q.push_back(32'h0);
    g_stall = 1'b0; step();
    g_stall = 1'b1;
    wait_new("t6_i0");
    lat = 2;
    req_q.push_back(32'h4);
    g_stall = 1'b0; step();
    g_rst = 1'b1; step();
    g_rst = 1'b0; step();
    chk("t6_late_valid_low", {31'b0, InstrValidF}, 32'd0);
    chk("t6_late_nop", InstrF, NOP);
    chk("t6_boot_no_req", {31'b0, mif.MemReq}, 32'd0);
    chk("t6_boot_pcf", PCF, RPC);
    req_q.push_back(RPC); instr_q.push_back(RPC);
    step();
    chk("t6_first_req", {31'b0, mif.MemReq}, 32'd1);
    chk("t6_first_addr", mif.MemAddr, RPC);
    g_stall = 1'b1;
    wait_new("t6_i100");

    chk("req_q_drained", req_q.size(), 32'd0);
    chk("instr_q_drained", instr_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
